// File: rtl/mem_access_stage.sv
// Data-memory access stage: issues one req/ack transaction per load/store,
// formats load data for MEM/WB and stalls the pipeline until the access completes.
module mem_access_stage #(
    parameter int XLEN   = 64,
    parameter int STRB_W = XLEN / 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_i,
    input  logic              mem_read_i,
    input  logic              mem_write_i,
    input  logic [2:0]        funct3_i,
    input  logic [XLEN-1:0]   addr_i,
    input  logic [XLEN-1:0]   wdata_i,
    output logic [XLEN-1:0]   load_data_o,
    output logic              stall_o,
    output logic              misalign_o,
    output logic              dmem_req_o,
    output logic              dmem_we_o,
    output logic [XLEN-1:0]   dmem_addr_o,
    output logic [XLEN-1:0]   dmem_wdata_o,
    output logic [STRB_W-1:0] dmem_wstrb_o,
    input  logic              dmem_ack_i,
    input  logic [XLEN-1:0]   dmem_rdata_i
);
    localparam int OFF_W = $clog2(STRB_W);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state_q, state_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [XLEN-1:0]   addr_q, addr_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0] wstrb_q, wstrb_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [OFF_W-1:0]  off_q, off_d;
    logic [XLEN-1:0]   loadData_q, loadData_d;

    logic              access;
    logic              illegal;
    logic              misaligned;
    logic [OFF_W-1:0]  off;
    logic [OFF_W:0]    sizeBytes;
    logic [STRB_W-1:0] byteMask;
    logic [XLEN-1:0]   storeMasked;
    logic [XLEN-1:0]   loadShifted;
    logic [XLEN-1:0]   loadFormatted;

    // Decode the incoming access; a simultaneous read and write is treated as a write.
    always_comb begin
        access      = valid_i & (mem_read_i | mem_write_i);
        off         = addr_i[OFF_W-1:0];
        sizeBytes   = (OFF_W+1)'(1) << funct3_i[1:0];
        misaligned  = (off & OFF_W'(sizeBytes - 1'b1)) != '0;
        illegal     = mem_write_i ? funct3_i[2] : (funct3_i == 3'b111);
        byteMask    = '0;
        storeMasked = '0;
        for (int i = 0; i < STRB_W; i++) begin
            byteMask[i]           = (OFF_W+1)'(i) < sizeBytes;
            storeMasked[8*i +: 8] = byteMask[i] ? wdata_i[8*i +: 8] : 8'h00;
        end
    end

    // Load data is formatted from the captured funct3/offset, not the live inputs.
    always_comb begin
        loadShifted = dmem_rdata_i >> {off_q, 3'b000};
        case (funct3_q)
            3'b000:  loadFormatted = {{(XLEN-8){loadShifted[7]}}, loadShifted[7:0]};
            3'b001:  loadFormatted = {{(XLEN-16){loadShifted[15]}}, loadShifted[15:0]};
            3'b010:  loadFormatted = {{(XLEN-32){loadShifted[31]}}, loadShifted[31:0]};
            3'b100:  loadFormatted = {{(XLEN-8){1'b0}}, loadShifted[7:0]};
            3'b101:  loadFormatted = {{(XLEN-16){1'b0}}, loadShifted[15:0]};
            3'b110:  loadFormatted = {{(XLEN-32){1'b0}}, loadShifted[31:0]};
            default: loadFormatted = loadShifted;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        funct3_d   = funct3_q;
        off_d      = off_q;
        loadData_d = loadData_q;
        stall_o    = 1'b0;
        misalign_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (access) begin
                    if (illegal | misaligned) begin
                        misalign_o = 1'b1;
                    end else begin
                        stall_o  = 1'b1;
                        req_d    = 1'b1;
                        we_d     = mem_write_i;
                        addr_d   = {addr_i[XLEN-1:OFF_W], {OFF_W{1'b0}}};
                        wdata_d  = mem_write_i ? (storeMasked << {off, 3'b000}) : '0;
                        wstrb_d  = mem_write_i ? (byteMask << off) : '0;
                        funct3_d = funct3_i;
                        off_d    = off;
                        state_d  = BUSY;
                    end
                end
            end
            BUSY: begin
                stall_o = 1'b1;
                if (dmem_ack_i) begin
                    req_d = 1'b0;
                    if (!we_q) begin
                        loadData_d = loadFormatted;
                    end
                    state_d = DONE;
                end
            end
            // One unstalled cycle lets the pipeline advance past the finished instruction.
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (reset) begin
            stall_o    = 1'b0;
            misalign_o = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            funct3_q   <= '0;
            off_q      <= '0;
            loadData_q <= '0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            funct3_q   <= funct3_d;
            off_q      <= off_d;
            loadData_q <= loadData_d;
        end
    end

    assign load_data_o  = loadData_q;
    assign dmem_req_o   = req_q;
    assign dmem_we_o    = we_q;
    assign dmem_addr_o  = addr_q;
    assign dmem_wdata_o = wdata_q;
    assign dmem_wstrb_o = wstrb_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: stimulus queues expected requests and
// completions from a byte-level reference model; a negedge monitor checks them.
module tb_mem_access_stage;
    logic        clk = 1'b0;
    logic        reset;
    logic        valid_i, mem_read_i, mem_write_i;
    logic [2:0]  funct3_i;
    logic [63:0] addr_i, wdata_i;
    logic [63:0] load_data_o;
    logic        stall_o, misalign_o;
    logic        dmem_req_o, dmem_we_o;
    logic [63:0] dmem_addr_o, dmem_wdata_o;
    logic [7:0]  dmem_wstrb_o;
    logic        dmem_ack_i;
    logic [63:0] dmem_rdata_i;

    typedef struct {
        logic [63:0] addr;
        logic [63:0] wdata;
        logic        we;
        logic [7:0]  wstrb;
    } reqExp_t;

    typedef struct {
        logic [63:0] data;
        int          stallLen;
    } doneExp_t;

    reqExp_t     reqQ[$];
    doneExp_t    doneQ[$];
    reqExp_t     held;
    int          misPending = 0;
    int          vectors = 0;
    int          errors = 0;
    logic [63:0] expLoad = 64'd0;

    mem_access_stage #(.XLEN(64), .STRB_W(8)) dut (
        .clk(clk), .reset(reset),
        .valid_i(valid_i), .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
        .funct3_i(funct3_i), .addr_i(addr_i), .wdata_i(wdata_i),
        .load_data_o(load_data_o), .stall_o(stall_o), .misalign_o(misalign_o),
        .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
        .dmem_wdata_o(dmem_wdata_o), .dmem_wstrb_o(dmem_wstrb_o),
        .dmem_ack_i(dmem_ack_i), .dmem_rdata_i(dmem_rdata_i)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Byte-level model: size from funct3[1:0], lanes chosen by the low address bits.
    function automatic void refModel(input logic [2:0] f3, input logic [63:0] addr,
                                     input logic [63:0] wdata, input logic [63:0] rdata,
                                     input logic isWrite, output logic bad,
                                     output logic [63:0] expWdata, output logic [7:0] expStrb,
                                     output logic [63:0] expData);
        int          size;
        int          off;
        logic [63:0] mask;
        logic [63:0] v;
        size     = 1 << f3[1:0];
        off      = int'(addr % 64'd8);
        mask     = (size == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * size)) - 64'd1);
        bad      = ((off % size) != 0) || (isWrite ? f3[2] : (f3 == 3'b111));
        expWdata = (wdata & mask) << (8 * off);
        expStrb  = 8'(((1 << size) - 1) << off);
        v        = (rdata >> (8 * off)) & mask;
        if (!f3[2] && size < 8 && v[8 * size - 1]) v = v | ~mask;
        expData  = v;
    endfunction

    task automatic applyStimulus(input logic [2:0] f3, input logic [63:0] addr, input logic [63:0] wdata,
                                 input logic isWrite, input logic rdToo, input int delay,
                                 input logic [63:0] rdata);
        logic        bad;
        logic [63:0] eW, eL;
        logic [7:0]  eS;
        reqExp_t     r;
        doneExp_t    d;
        bit          got;
        refModel(f3, addr, wdata, rdata, isWrite, bad, eW, eS, eL);
        if (bad) begin
            misPending++;
        end else begin
            r.addr  = {addr[63:3], 3'b000};
            r.we    = isWrite;
            r.wdata = eW;
            r.wstrb = isWrite ? eS : 8'h00;
            reqQ.push_back(r);
            if (!isWrite) expLoad = eL;
            d.data     = expLoad;
            d.stallLen = 1 + delay;
            doneQ.push_back(d);
        end
        @(posedge clk); #1;
        valid_i     = 1'b1;
        mem_read_i  = !isWrite | rdToo;
        mem_write_i = isWrite;
        funct3_i    = f3;
        addr_i      = addr;
        wdata_i     = wdata;
        if (bad) begin
            @(posedge clk); #1;
        end else begin
            got = 0;
            for (int i = 0; i < 10; i++) begin
                @(posedge clk); #1;
                if (dmem_req_o) begin
                    got = 1;
                    break;
                end
            end
            checkOutput("req_issued", 64'(got), 64'd1);
            if (got) begin
                repeat (delay - 1) begin
                    @(posedge clk); #1;
                end
                dmem_ack_i   = 1'b1;
                dmem_rdata_i = rdata;
                @(posedge clk); #1;
                dmem_ack_i   = 1'b0;
                dmem_rdata_i = {$urandom, $urandom};
                @(posedge clk); #1;
            end
        end
        valid_i     = 1'b0;
        mem_read_i  = 1'b0;
        mem_write_i = 1'b0;
    endtask

    // Monitor: request launch, request stability, misalign pulses and completions.
    logic     prevReq = 1'b0;
    logic     prevStall = 1'b0;
    int       stallRun = 0;
    reqExp_t  r;
    doneExp_t d;
    always @(negedge clk) begin
        if (reset) begin
            doneQ.delete();
            stallRun  = 0;
            prevReq   = 1'b0;
            prevStall = 1'b0;
        end else begin
            if (misalign_o) begin
                checkOutput("misalign_expected", 64'(misPending > 0), 64'd1);
                if (misPending > 0) misPending--;
                checkOutput("misalign_stall", 64'(stall_o), 64'd0);
                checkOutput("misalign_req", 64'(dmem_req_o), 64'd0);
            end
            if (dmem_req_o && !prevReq) begin
                checkOutput("req_expected", 64'(reqQ.size() > 0), 64'd1);
                if (reqQ.size() > 0) begin
                    r = reqQ.pop_front();
                    held = r;
                    checkOutput("req_addr", dmem_addr_o, r.addr);
                    checkOutput("req_we", 64'(dmem_we_o), 64'(r.we));
                    checkOutput("req_wstrb", 64'(dmem_wstrb_o), 64'(r.wstrb));
                    if (r.we) checkOutput("req_wdata", dmem_wdata_o, r.wdata);
                end
            end else if (dmem_req_o) begin
                checkOutput("req_addr_stable", dmem_addr_o, held.addr);
                checkOutput("req_strb_stable", 64'(dmem_wstrb_o), 64'(held.wstrb));
            end
            if (stall_o) begin
                stallRun++;
            end else if (prevStall) begin
                checkOutput("done_expected", 64'(doneQ.size() > 0), 64'd1);
                if (doneQ.size() > 0) begin
                    d = doneQ.pop_front();
                    checkOutput("load_data", load_data_o, d.data);
                    checkOutput("stall_cycles", 64'(stallRun), 64'(d.stallLen));
                end
                stallRun = 0;
            end
            prevReq   = dmem_req_o;
            prevStall = stall_o;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [2:0]  f3;
        logic [63:0] a;
        int          sz;
        reset        = 1'b1;
        valid_i      = 1'b0;
        mem_read_i   = 1'b0;
        mem_write_i  = 1'b0;
        funct3_i     = 3'b000;
        addr_i       = '0;
        wdata_i      = '0;
        dmem_ack_i   = 1'b0;
        dmem_rdata_i = '0;
        #2;
        checkOutput("reset_stall", 64'(stall_o), 64'd0);
        checkOutput("reset_misalign", 64'(misalign_o), 64'd0);
        checkOutput("reset_req", 64'(dmem_req_o), 64'd0);
        checkOutput("reset_we", 64'(dmem_we_o), 64'd0);
        checkOutput("reset_addr", dmem_addr_o, 64'd0);
        checkOutput("reset_wdata", dmem_wdata_o, 64'd0);
        checkOutput("reset_wstrb", 64'(dmem_wstrb_o), 64'd0);
        checkOutput("reset_load", load_data_o, 64'd0);
        #10 reset = 1'b0;

        applyStimulus(3'b011, 64'h100, 64'h0, 1'b0, 1'b0, 1, 64'h1122334455667788);
        applyStimulus(3'b000, 64'h103, 64'h0, 1'b0, 1'b0, 1, 64'h0000000080000000);
        applyStimulus(3'b100, 64'h103, 64'h0, 1'b0, 1'b0, 2, 64'h0000000080000000);
        applyStimulus(3'b001, 64'h206, 64'hABCD, 1'b1, 1'b0, 1, 64'h0);
        applyStimulus(3'b010, 64'h102, 64'h0, 1'b0, 1'b0, 1, 64'h0);
        applyStimulus(3'b111, 64'h100, 64'h0, 1'b0, 1'b0, 1, 64'h0);
        applyStimulus(3'b100, 64'h300, 64'h12, 1'b1, 1'b0, 1, 64'h0);
        applyStimulus(3'b011, 64'h108, 64'h0, 1'b0, 1'b0, 5, 64'hDEADBEEFCAFEF00D);
        applyStimulus(3'b010, 64'h404, 64'h89ABCDEF, 1'b1, 1'b1, 3, 64'h0);

        // Spurious ack while idle must not disturb anything.
        @(posedge clk); #1;
        dmem_ack_i   = 1'b1;
        dmem_rdata_i = 64'hFFFF_0000_FFFF_0000;
        @(posedge clk); #1;
        dmem_ack_i   = 1'b0;
        checkOutput("spurious_req", 64'(dmem_req_o), 64'd0);
        checkOutput("spurious_stall", 64'(stall_o), 64'd0);
        checkOutput("spurious_load", load_data_o, expLoad);

        // Reset in the middle of a load, followed by a late ack.
        reqQ.push_back('{addr: 64'h500, wdata: 64'h0, we: 1'b0, wstrb: 8'h00});
        @(posedge clk); #1;
        valid_i    = 1'b1;
        mem_read_i = 1'b1;
        funct3_i   = 3'b011;
        addr_i     = 64'h500;
        @(posedge clk); #1;
        checkOutput("rst_busy_req", 64'(dmem_req_o), 64'd1);
        @(negedge clk); #1;
        reset      = 1'b1;
        valid_i    = 1'b0;
        mem_read_i = 1'b0;
        #1;
        checkOutput("rst_req_drop", 64'(dmem_req_o), 64'd0);
        checkOutput("rst_stall_drop", 64'(stall_o), 64'd0);
        @(negedge clk); #1;
        reset   = 1'b0;
        expLoad = 64'd0;
        @(posedge clk); #1;
        dmem_ack_i   = 1'b1;
        dmem_rdata_i = 64'h5555_AAAA_5555_AAAA;
        @(posedge clk); #1;
        dmem_ack_i = 1'b0;
        checkOutput("late_ack_req", 64'(dmem_req_o), 64'd0);
        checkOutput("late_ack_stall", 64'(stall_o), 64'd0);
        checkOutput("late_ack_load", load_data_o, 64'd0);
        applyStimulus(3'b011, 64'h600, 64'h0, 1'b0, 1'b0, 1, 64'h0102030405060708);

        for (int n = 0; n < 40; n++) begin
            f3 = 3'($urandom_range(0, 7));
            a  = {$urandom, $urandom};
            sz = 1 << f3[1:0];
            if ($urandom_range(0, 3) != 0) a[2:0] = 3'((int'(a[2:0]) / sz) * sz);
            applyStimulus(f3, a, {$urandom, $urandom}, 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), $urandom_range(1, 4), {$urandom, $urandom});
        end

        repeat (4) @(posedge clk);
        #1;
        checkOutput("scoreboard_drained", 64'(reqQ.size() + doneQ.size() + misPending), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
